// File: rtl/m_immediate_decode_stage.sv
// Immediate extraction stage: decodes RV immediates at the input and
// registers them behind a 2-entry skid buffer with valid/ready handshakes.
module m_immediate_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] F_I  = 3'd1;
    localparam logic [2:0] F_S  = 3'd2;
    localparam logic [2:0] F_B  = 3'd3;
    localparam logic [2:0] F_U  = 3'd4;
    localparam logic [2:0] F_J  = 3'd5;
    localparam logic [2:0] F_Z  = 3'd6;
    localparam logic [2:0] F_SH = 3'd7;
    localparam bit IS64 = (XLEN == 64);

    logic [31:0]      raw;
    logic             raw_sext;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic             m_valid_q, m_valid_d;
    logic             k_valid_q, k_valid_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d;
    logic [XLEN-1:0]  k_imm_q, k_imm_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic [TAG_W-1:0] k_tag_q, k_tag_d;
    logic             m_ill_q, m_ill_d;
    logic             k_ill_q, k_ill_d;

    logic             in_xfer;
    logic             out_xfer;

    // opcode bits never contribute to any immediate
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Gather the immediate bits for the selected format into 32 bits
    always_comb begin
        raw      = '0;
        raw_sext = 1'b0;
        dec_ill  = 1'b0;
        unique case (in_fmt)
            F_I: begin
                raw      = {{20{in_instr[31]}}, in_instr[31:20]};
                raw_sext = 1'b1;
            end
            F_S: begin
                raw      = {{20{in_instr[31]}}, in_instr[31:25],
                            in_instr[11:7]};
                raw_sext = 1'b1;
            end
            F_B: begin
                raw      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
                raw_sext = 1'b1;
            end
            F_U: begin
                raw      = {in_instr[31:12], 12'b0};
                raw_sext = 1'b1;
            end
            F_J: begin
                raw      = {{11{in_instr[31]}}, in_instr[31],
                            in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
                raw_sext = 1'b1;
            end
            F_Z: begin
                raw = {27'b0, in_instr[19:15]};
            end
            F_SH: begin
                if (IS64) begin
                    raw = {26'b0, in_instr[25:20]};
                end else begin
                    raw     = {27'b0, in_instr[24:20]};
                    dec_ill = in_instr[25];
                end
            end
            default: begin
                raw = '0;
            end
        endcase
    end

    // Widen to XLEN, replicating the sign only for signed formats
    always_comb begin
        if (raw_sext) begin
            dec_imm = XLEN'($signed(raw));
        end else begin
            dec_imm = XLEN'(raw);
        end
    end

    assign in_ready = !k_valid_q;
    assign in_xfer  = in_valid && !k_valid_q;
    assign out_xfer = m_valid_q && out_ready;

    // Skid-buffer steering: K refills M first, else new entries land in M or K
    always_comb begin
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        m_imm_d   = m_imm_q;
        m_tag_d   = m_tag_q;
        m_ill_d   = m_ill_q;
        k_imm_d   = k_imm_q;
        k_tag_d   = k_tag_q;
        k_ill_d   = k_ill_q;
        if (flush) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (k_valid_q) begin
            if (out_xfer) begin
                m_valid_d = 1'b1;
                m_imm_d   = k_imm_q;
                m_tag_d   = k_tag_q;
                m_ill_d   = k_ill_q;
                k_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_valid_q || out_xfer) begin
                m_valid_d = 1'b1;
                m_imm_d   = dec_imm;
                m_tag_d   = in_tag;
                m_ill_d   = dec_ill;
            end else begin
                k_valid_d = 1'b1;
                k_imm_d   = dec_imm;
                k_tag_d   = in_tag;
                k_ill_d   = dec_ill;
            end
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end
    end

    // Valid bits: asynchronously cleared so entries vanish on reset at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            k_valid_q <= k_valid_d;
        end
    end

    // Payload registers carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        m_imm_q <= m_imm_d;
        m_tag_q <= m_tag_d;
        m_ill_q <= m_ill_d;
        k_imm_q <= k_imm_d;
        k_tag_q <= k_tag_d;
        k_ill_q <= k_ill_d;
    end

    assign out_valid   = m_valid_q;
    assign out_imm     = m_valid_q ? m_imm_q : '0;
    assign out_tag     = m_valid_q ? m_tag_q : '0;
    assign out_illegal = m_valid_q && m_ill_q;

endmodule

// File: tb/tb_m_immediate_decode_stage.sv
// Scoreboard bench for m_immediate_decode_stage, run at XLEN 32 and 64
// side by side on a shared input stream.
module tb_m_immediate_decode_stage;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic        ill32;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic        r32, v32, il32;
    logic [31:0] imm32, tag32;
    logic        r64, v64, il64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    logic        dir_v = 1'b0;
    logic [31:0] dir_e32 = '0;
    logic [63:0] dir_e64 = '0;
    logic        dir_il = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    m_immediate_decode_stage #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r32),
        .in_fmt(in_fmt), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32), .out_illegal(il32)
    );

    m_immediate_decode_stage #(.XLEN(64), .TAG_W(32)) u64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64),
        .in_fmt(in_fmt), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64), .out_illegal(il64)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: value of the immediate as a signed integer, then
    // truncated to the target width.
    function automatic logic [63:0] ref_imm(input logic [2:0] f,
                                            input logic [31:0] ins,
                                            input bit x64);
        longint v;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [31:0] u32v;
        logic signed [20:0] j21;
        v = 0;
        case (f)
            3'd1: begin i12 = ins[31:20]; v = i12; end
            3'd2: begin i12 = {ins[31:25], ins[11:7]}; v = i12; end
            3'd3: begin
                b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v = b13;
            end
            3'd4: begin u32v = {ins[31:12], 12'h000}; v = u32v; end
            3'd5: begin
                j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v = j21;
            end
            3'd6: v = longint'(ins[19:15]);
            3'd7: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // Monitor: occupancy, head-of-queue compare, then model update
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            chk("out_valid32", {63'b0, v32}, {63'b0, q.size() != 0});
            chk("out_valid64", {63'b0, v64}, {63'b0, q.size() != 0});
            chk("in_ready32", {63'b0, r32}, {63'b0, q.size() < 2});
            chk("in_ready64", {63'b0, r64}, {63'b0, q.size() < 2});
            if (q.size() != 0 && v32) begin
                chk("imm32", {32'b0, imm32}, {32'b0, q[0].imm32});
                chk("ill32", {63'b0, il32}, {63'b0, q[0].ill32});
                chk("tag32", {32'b0, tag32}, {32'b0, q[0].tag});
            end
            if (q.size() != 0 && v64) begin
                chk("imm64", imm64, q[0].imm64);
                chk("ill64", {63'b0, il64}, 64'd0);
                chk("tag64", {32'b0, tag64}, {32'b0, q[0].tag});
            end
            if (v32 && out_ready && q.size() != 0) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && r32 && q.size() < 2) begin
                if (dir_v) begin
                    e.imm32 = dir_e32;
                    e.imm64 = dir_e64;
                    e.ill32 = dir_il;
                end else begin
                    e.imm32 = ref_imm(in_fmt, in_instr, 1'b0) & 32'hFFFFFFFF;
                    e.imm64 = ref_imm(in_fmt, in_instr, 1'b1);
                    e.ill32 = (in_fmt == 3'd7) && in_instr[25];
                end
                e.tag = in_tag;
                q.push_back(e);
            end
        end
    end

    task automatic offer(input logic [2:0] f, input logic [31:0] ins,
                         input logic [31:0] tg);
        in_valid = 1'b1;
        in_fmt   = f;
        in_instr = ins;
        in_tag   = tg;
    endtask

    task automatic wait_accept(output int n);
        bit acc;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = r32;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        dir_v = 1'b0;
    endtask

    task automatic send_dir(input logic [2:0] f, input logic [31:0] ins,
                            input logic [31:0] e32, input logic [63:0] e64,
                            input logic il, input logic [31:0] tg);
        int n;
        dir_v   = 1'b1;
        dir_e32 = e32;
        dir_e64 = e64;
        dir_il  = il;
        offer(f, ins, tg);
        wait_accept(n);
        chk("throughput", n, 1);
    endtask

    task automatic send(input logic [31:0] tg);
        int n;
        offer(3'($urandom_range(0, 7)), $urandom, tg);
        wait_accept(n);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        #12;
        chk("rst_out_valid", {63'b0, v32}, 64'd0);
        chk("rst_in_ready", {63'b0, r32}, 64'd1);
        chk("rst_imm32", {32'b0, imm32}, 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", {32'b0, tag32 | tag64}, 64'd0);
        chk("rst_ill", {62'b0, il32, il64}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(1);

        send_dir(3'd1, 32'hFFF00093, 32'hFFFFFFFF,
                 64'hFFFFFFFF_FFFFFFFF, 1'b0, 32'h100);
        send_dir(3'd2, 32'hFE20AE23, 32'hFFFFFFFC,
                 64'hFFFFFFFF_FFFFFFFC, 1'b0, 32'h104);
        send_dir(3'd3, 32'hFE000FE3, 32'hFFFFFFFE,
                 64'hFFFFFFFF_FFFFFFFE, 1'b0, 32'h108);
        send_dir(3'd4, 32'h123450B7, 32'h12345000,
                 64'h00000000_12345000, 1'b0, 32'h10C);
        send_dir(3'd5, 32'h001000EF, 32'h00000800,
                 64'h00000000_00000800, 1'b0, 32'h110);
        send_dir(3'd4, 32'h800000B7, 32'h80000000,
                 64'hFFFFFFFF_80000000, 1'b0, 32'h114);
        send_dir(3'd7, 32'h03F00013, 32'h0000001F,
                 64'h00000000_0000003F, 1'b1, 32'h118);
        send_dir(3'd6, 32'h000F8073, 32'h0000001F,
                 64'h00000000_0000001F, 1'b0, 32'h11C);
        send_dir(3'd0, 32'hFFFFFFFF, 32'h00000000,
                 64'h00000000_00000000, 1'b0, 32'h120);
        cycles(2);

        out_ready = 1'b0;
        send(32'hA);
        send(32'hB);
        chk("bp_in_ready32", {63'b0, r32}, 64'd0);
        chk("bp_in_ready64", {63'b0, r64}, 64'd0);
        offer(3'd1, $urandom, 32'hC);
        cycles(3);
        chk("bp_hold", {63'b0, r32}, 64'd0);
        out_ready = 1'b1;
        wait_accept(n);
        cycles(4);
        chk("bp_drained", {63'b0, v32}, 64'd0);

        out_ready = 1'b0;
        send(32'hD);
        send(32'hE);
        offer(3'd2, $urandom, 32'hF);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {63'b0, v32 | v64}, 64'd0);
        chk("flush_in_ready", {63'b0, r32 & r64}, 64'd1);
        out_ready = 1'b1;
        cycles(4);

        repeat (800) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_fmt    = 3'($urandom_range(0, 7));
            in_instr  = $urandom;
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycles(1);
        end
        in_valid = 1'b0;
        flush = 1'b0;

        out_ready = 1'b0;
        send(32'h55);
        send(32'h66);
        chk("pre_rst_valid", {63'b0, v32}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid32", {63'b0, v32}, 64'd0);
        chk("async_rst_valid64", {63'b0, v64}, 64'd0);
        chk("async_rst_ready", {63'b0, r32 & r64}, 64'd1);
        chk("async_rst_imm", imm64 | {32'b0, imm32}, 64'd0);
        cycles(2);
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
